// File: rtl/comparator_4bit.sv
// Registered magnitude comparator: one-hot lower/equal/greater flags for two WIDTH-bit operands.
// The compare can be unsigned or two's-complement, and the output stage can be registered or combinational.
module comparator_4bit #(
  parameter int WIDTH        = 4,
  parameter bit SIGNED_CMP   = 1'b0,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lower,
  output logic             equal,
  output logic             greater
);

  // Streaming block with no handshake: a new a/b pair is accepted on every rising
  // clk edge. Each pair produces exactly one result, one cycle later when the
  // output stage is registered, or at once when it is combinational.

  logic lower_d;
  logic equal_d;
  logic greater_d;

  // greater is derived from the other two flags, so the flags are one-hot by construction.
  always_comb begin
    equal_d = (a == b);
    if (SIGNED_CMP) begin
      lower_d = ($signed(a) < $signed(b));
    end else begin
      lower_d = (a < b);
    end
    greater_d = ~lower_d & ~equal_d;
  end

  generate
    if (REGISTER_OUT) begin : g_reg
      logic lower_q;
      logic equal_q;
      logic greater_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lower_q   <= 1'b0;
          equal_q   <= 1'b0;
          greater_q <= 1'b0;
        end else begin
          lower_q   <= lower_d;
          equal_q   <= equal_d;
          greater_q <= greater_d;
        end
      end

      assign lower   = lower_q;
      assign equal   = equal_q;
      assign greater = greater_q;
    end else begin : g_comb
      // Even without the register stage, a low rst_n holds all flags at 0.
      assign lower   = rst_n & lower_d;
      assign equal   = rst_n & equal_d;
      assign greater = rst_n & greater_d;
    end
  endgenerate

endmodule

// File: tb/tb_comparator_4bit.sv
// Directed bench for comparator_4bit.
// It covers the unsigned registered, signed registered and unsigned combinational variants.
module tb_comparator_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;

  logic u_lower, u_equal, u_greater;
  logic s_lower, s_equal, s_greater;
  logic c_lower, c_equal, c_greater;

  int checks;
  int errors;
  logic [2:0] exp_q[$];

  comparator_4bit #(.WIDTH(4), .SIGNED_CMP(1'b0), .REGISTER_OUT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .lower(u_lower), .equal(u_equal), .greater(u_greater)
  );

  comparator_4bit #(.WIDTH(4), .SIGNED_CMP(1'b1), .REGISTER_OUT(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .lower(s_lower), .equal(s_equal), .greater(s_greater)
  );

  comparator_4bit #(.WIDTH(4), .SIGNED_CMP(1'b0), .REGISTER_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .lower(c_lower), .equal(c_equal), .greater(c_greater)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags are packed as {lower, equal, greater}.
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input int x, input int y);
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic int to_s4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Drive a pair at negedge, check the combinational copy, then check the registered copies after the edge.
  task automatic apply(input string tag, input int av, input int bv,
                       input logic [2:0] exp_u, input logic [2:0] exp_s);
    logic [2:0] e;
    @(negedge clk);
    a = av[3:0];
    b = bv[3:0];
    exp_q.push_back(exp_u);
    #1;
    check({tag, "_comb"}, {c_lower, c_equal, c_greater}, exp_u);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_uns"}, {u_lower, u_equal, u_greater}, e);
    check({tag, "_sgn"}, {s_lower, s_equal, s_greater}, exp_s);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = 4'd3;
    b      = 4'd3;

    // Reset holds all flags at zero while the clock runs.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_uns",  {u_lower, u_equal, u_greater}, 3'b000);
      check("rst_comb", {c_lower, c_equal, c_greater}, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_hold", {u_lower, u_equal, u_greater}, 3'b000);
    @(posedge clk);
    #1;
    check("rst_rel_eq", {u_lower, u_equal, u_greater}, 3'b010);

    // Small sweep; all operands are non-negative, so the signed and unsigned results agree.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        apply("sweep", i, j, ref_cmp(i, j), ref_cmp(i, j));
      end
    end

    // Extremes; in the signed view, 15 means -1.
    apply("ext_0_15",  0,  15, 3'b100, 3'b001);
    apply("ext_15_0",  15, 0,  3'b001, 3'b100);
    apply("ext_15_15", 15, 15, 3'b010, 3'b010);
    apply("ext_0_0",   0,  0,  3'b010, 3'b010);

    // Signed cases: -1 < +1 and -8 < +7.
    apply("sgn_m1_p1", 4'b1111, 4'b0001, 3'b001, 3'b100);
    apply("sgn_m8_p7", 4'b1000, 4'b0111, 3'b001, 3'b100);

    // Exhaustive sweep with a one-hot check.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        apply("exh", i, j, ref_cmp(i, j), ref_cmp(to_s4(i), to_s4(j)));
        check("onehot", {2'b00, ($countones({u_lower, u_equal, u_greater}) == 1)}, 3'b001);
      end
    end

    // Pulse reset between clock edges in the middle of the stream.
    apply("mid_pre", 7, 2, 3'b001, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_uns",  {u_lower, u_equal, u_greater}, 3'b000);
    check("mid_rst_sgn",  {s_lower, s_equal, s_greater}, 3'b000);
    check("mid_rst_comb", {c_lower, c_equal, c_greater}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_hold", {u_lower, u_equal, u_greater}, 3'b000);
    @(posedge clk);
    #1;
    check("mid_rel_gt", {u_lower, u_equal, u_greater}, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
